// File: rtl/cpu_pkg.sv
// Shared field layout, sizing and FSM state codes for the
// instruction reader and its decoder.
package cpu_pkg;

    localparam int IW    = 18;
    localparam int DEPTH = 10;

    localparam int OP_W  = 4;
    localparam int REG_W = 3;
    localparam int IMM_W = 8;

    localparam int OP_LSB  = 14;
    localparam int R1_LSB  = 11;
    localparam int R2_LSB  = 8;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] HALT_OP = 4'b1111;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_LATCH   = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

endpackage

// File: rtl/instruction_decode.sv
// Pure combinational split of an instruction word into its
// opcode, register and immediate fields.
module instruction_decode #(
    parameter int IW = cpu_pkg::IW
) (
    input  logic [IW-1:0] word_i,
    input  logic          unused_i,
    output logic [3:0]    opCode_o,
    output logic [2:0]    regID1_o,
    output logic [2:0]    regID2_o,
    output logic [7:0]    immValue_o
);
    import cpu_pkg::*;

    assign opCode_o   = word_i[OP_LSB  +: OP_W];
    assign regID1_o   = word_i[R1_LSB  +: REG_W];
    assign regID2_o   = word_i[R2_LSB  +: REG_W];
    assign immValue_o = word_i[IMM_LSB +: IMM_W];

    logic unused_ok;
    assign unused_ok = unused_i;

endmodule

// File: rtl/instruction_reader.sv
// Walks an instruction store slot by slot, presenting each word
// over a valid/ready handshake until halt or end of program.
module instruction_reader #(
    parameter int         DEPTH   = cpu_pkg::DEPTH,
    parameter int         IW      = cpu_pkg::IW,
    parameter logic [3:0] HALT_OP = cpu_pkg::HALT_OP
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    progLen,
    output logic [3:0]    memAddr,
    input  logic [IW-1:0] memData,
    output logic [IW-1:0] instruction,
    output logic [3:0]    opCode,
    output logic [2:0]    regID1,
    output logic [2:0]    regID2,
    output logic [7:0]    immValue,
    output logic          instrValid,
    input  logic          instrReady,
    output logic [3:0]    pc,
    output logic          busy,
    output logic          done
);
    import cpu_pkg::*;

    localparam logic [3:0] LEN_MAX = 4'(DEPTH);
    localparam logic [3:0] PC_MAX  = 4'(DEPTH - 1);

    logic [2:0]    state_q, state_d;
    logic [3:0]    pc_q, pc_d;
    logic [3:0]    len_q, len_d;
    logic [IW-1:0] instr_q, instr_d;

    instruction_decode #(.IW(IW)) u_dec (
        .word_i     (instr_q),
        .unused_i   (1'b0),
        .opCode_o   (opCode),
        .regID1_o   (regID1),
        .regID2_o   (regID2),
        .immValue_o (immValue)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        instr_d = instr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (progLen != 4'd0) begin
                        pc_d    = 4'd0;
                        len_d   = (progLen > LEN_MAX) ? LEN_MAX : progLen;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                instr_d = memData;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (instrReady) begin
                    // PC_MAX guard keeps pc inside the store even if len misbehaves
                    if (opCode == HALT_OP || pc_q == len_q - 4'd1
                        || pc_q == PC_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= 4'd0;
            len_q   <= 4'd0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            instr_q <= instr_d;
        end
    end

    assign memAddr     = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instrValid  = (state_q == S_PRESENT);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_instruction_reader.sv
// Randomized bench for instruction_reader with a transaction-level
// model of presentation timing, program length and halt handling.
module tb_instruction_reader;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset, start, instrReady;
    logic [3:0]  progLen, memAddr, pc, opCode;
    logic [17:0] memData, instruction;
    logic [2:0]  regID1, regID2;
    logic [7:0]  immValue;
    logic        instrValid, busy, done;

    logic [17:0] mem [16];
    int checks = 0;
    int errors = 0;
    int m_pc   = 0;

    always #5 clock = ~clock;

    always @(posedge clock) memData <= mem[memAddr];

    instruction_reader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .progLen     (progLen),
        .memAddr     (memAddr),
        .memData     (memData),
        .instruction (instruction),
        .opCode      (opCode),
        .regID1      (regID1),
        .regID2      (regID2),
        .immValue    (immValue),
        .instrValid  (instrValid),
        .instrReady  (instrReady),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input bit halts);
        for (int i = 0; i < 16; i++) begin
            int op;
            op = $urandom % 15;
            if (halts && ($urandom % 6 == 0)) op = 15;
            mem[i] = {op[3:0], 14'($urandom)};
        end
    endtask

    // One program run; timing expressed as cycles after start acceptance.
    task automatic run(input int plen, input int rdy_pct,
                       input bit wild, output int presented);
        int n, idx, nv, dn, t, w, op;
        n = (plen > DEPTH) ? DEPTH : plen;
        idx = 0;
        presented = 0;
        t = 0;
        dn = (n == 0) ? 1 : -1;
        nv = (n == 0) ? -1 : 3;
        @(negedge clock);
        start = 1'b1;
        progLen = plen[3:0];
        instrReady = 1'($urandom);
        forever begin
            @(negedge clock);
            t++;
            chk("addr_eq_pc", memAddr, pc);
            if (t == dn + 1) begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_pc", pc, m_pc);
                break;
            end
            if (t == dn) begin
                chk("done", done, 1);
                chk("done_busy", busy, 1);
                chk("done_valid", instrValid, 0);
                start = 1'b0;
                continue;
            end
            if (t > 300) begin
                chk("timeout", 0, 1);
                break;
            end
            start = wild ? 1'($urandom) : 1'b0;
            if (nv >= 0 && t >= nv) begin
                w  = int'(mem[idx]);
                op = w >> 14;
                chk("valid", instrValid, 1);
                chk("busy", busy, 1);
                chk("done_low", done, 0);
                chk("pc", pc, idx);
                chk("instr", instruction, w);
                chk("opCode", opCode, op);
                chk("regID1", regID1, (w >> 11) & 7);
                chk("regID2", regID2, (w >> 8) & 7);
                chk("imm", immValue, w & 255);
                instrReady = (($urandom % 100) < rdy_pct);
                if (instrReady) begin
                    presented++;
                    if (op == 15 || idx == n - 1) begin
                        dn = t + 1;
                        nv = -1;
                        m_pc = idx;
                    end else begin
                        idx++;
                        nv = t + 3;
                    end
                end
            end else begin
                chk("gap_valid", instrValid, 0);
                chk("gap_busy", busy, 1);
                chk("gap_done", done, 0);
                instrReady = 1'($urandom);
            end
        end
        start = 1'b0;
        instrReady = 1'b0;
    endtask

    initial begin
        int cnt;
        bit hit;
        reset = 1'b1;
        start = 1'b0;
        progLen = 4'd0;
        instrReady = 1'b0;
        fill_random(1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", instrValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instruction, 0);
        reset = 1'b0;

        mem[0] = 18'h04000;
        mem[1] = 18'h0A805;
        mem[2] = 18'h0B9FF;
        run(3, 100, 1'b0, cnt);
        chk("full_cnt", cnt, 3);
        chk("full_regs", {opCode, regID1, regID2, immValue}, {4'd2, 3'd7, 3'd1, 8'hFF});

        fill_random(1'b0);
        mem[1] = {HALT_OP, 14'h0};
        run(5, 100, 1'b0, cnt);
        chk("halt_cnt", cnt, 2);
        chk("halt_pc", pc, 1);

        run(0, 100, 1'b0, cnt);
        chk("zero_cnt", cnt, 0);

        fill_random(1'b0);
        run(15, 100, 1'b1, cnt);
        chk("len15_cnt", cnt, 10);

        fill_random(1'b0);
        run(6, 25, 1'b0, cnt);
        chk("bp_cnt", cnt, 6);

        for (int r = 0; r < 12; r++) begin
            fill_random(1'b1);
            run(int'($urandom % 16), 20 + int'($urandom % 81), 1'b1, cnt);
        end

        fill_random(1'b0);
        @(negedge clock);
        start = 1'b1;
        progLen = 4'd5;
        instrReady = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (instrValid && pc == 4'd2) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_reach", hit, 1);
        reset = 1'b1;
        instrReady = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_valid", instrValid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_pc", pc, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("mid_nodone", done, 0);
        end
        m_pc = 0;

        fill_random(1'b1);
        run(4, 60, 1'b1, cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_reader.md
INSTRUCTION_READER -- requirements
Module: instruction_reader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 10: number of instruction-memory slots.
REQ-002 The block SHALL have parameter IW, default 18: instruction width, laid out as opCode[17:14], regID1[13:11], regID2[10:8], immValue[7:0].
REQ-003 The block SHALL have parameter HALT_OP, default 4'b1111: the opcode that terminates a run.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin reading at slot 0.
REQ-007 The block SHALL have port progLen, input, 4 bits: number of loaded instructions, sampled only on an accepted start.
REQ-008 The block SHALL have port memAddr, output, 4 bits: read address to the instruction store.
REQ-009 The block SHALL have port memData, input, IW bits: store read data, valid one cycle after memAddr.
REQ-010 The block SHALL have port instruction, output, IW bits: the presented instruction word.
REQ-011 The block SHALL have port opCode, output, 4 bits: decoded field of instruction.
REQ-012 The block SHALL have ports regID1 and regID2, outputs, 3 bits each: decoded fields of instruction.
REQ-013 The block SHALL have port immValue, output, 8 bits: decoded field of instruction.
REQ-014 The block SHALL have port instrValid, output, 1 bit: instruction fields are valid and held.
REQ-015 The block SHALL have port instrReady, input, 1 bit: the consumer accepts the instruction.
REQ-016 The block SHALL have port pc, output, 4 bits: index of the current slot.
REQ-017 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, LATCH, PRESENT, and DONE.
REQ-020 In IDLE, start=1 with progLen≠0 SHALL load pc=0 and the internal length register len=min(progLen,DEPTH), then go to FETCH.
REQ-021 In IDLE, start=1 with progLen=0 SHALL go directly to DONE without presenting any instruction.
REQ-022 memAddr SHALL equal pc at all times.
REQ-023 FETCH SHALL go to LATCH unconditionally.
REQ-024 LATCH SHALL capture memData into instruction and the decoded fields, then go to PRESENT.
REQ-025 In PRESENT, instrValid SHALL be 1, and instruction and all fields SHALL stay stable until the handshake completes.
REQ-026 The handshake SHALL complete on the first cycle in PRESENT with instrReady=1; instrValid SHALL fall on the following cycle.
REQ-027 On handshake completion with opCode==HALT_OP or pc==len-1, the FSM SHALL go to DONE.
REQ-028 On handshake completion otherwise, pc SHALL increment by 1 and the FSM SHALL go to FETCH.
REQ-029 pc SHALL never exceed DEPTH-1; no wrap-around occurs.
REQ-030 DONE SHALL assert done for exactly one cycle, then go to IDLE; pc and fields keep their last values.
REQ-031 Latency: with start accepted in cycle N, instrValid SHALL first be 1 in cycle N+3.
REQ-032 Throughput: with instrReady held at 1, one instruction SHALL be presented every 3 cycles.
REQ-033 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-034 instrReady outside PRESENT SHALL have no effect.
REQ-035 A simultaneous start and handshake completion SHALL be treated as handshake only.

Reset
REQ-036 When reset=1 at a clock edge, the FSM SHALL go to IDLE and pc, len, instruction, and all fields SHALL be set to 0.
REQ-037 During and immediately after reset, instrValid, busy, and done SHALL be 0.
REQ-038 Reset SHALL take priority over every other input, including mid-run and in PRESENT.
REQ-039 Reset asserted mid-run SHALL abandon the run with no done pulse.

Structure
REQ-040 A shared package cpu_pkg SHALL hold the field widths and bit positions, HALT_OP, DEPTH, and the state enumeration.
REQ-041 One combinational sub-module, instruction_decode, SHALL split an IW-bit word into opCode, regID1, regID2, and immValue.

Verification
REQ-042 Scenario, full run: slots 0-2 hold 18'h04000, 18'h0A805, 18'h0B9FF, progLen=3, instrReady=1 → three presentations at cycles N+3, N+6, N+9; second has opCode=2, regID1=5, regID2=0, immValue=8'h05; done at N+10.
REQ-043 Scenario, early halt: slot 1 = {HALT_OP,14'h0}, progLen=5 → exactly two instructions presented, then done; pc=1.
REQ-044 Scenario, back-pressure: instrReady=0 for 4 cycles in PRESENT → instrValid and fields stay constant; advance occurs on the first cycle instrReady=1.
REQ-045 Scenario, length edge cases: progLen=0 → done at N+1 with instrValid never 1; progLen=15 → exactly 10 instructions presented (slots 0-9).
REQ-046 Scenario, reset mid-run: reset in PRESENT of slot 2 → next cycle state IDLE, pc=0, instrValid=0, busy=0, no done pulse.
REQ-047 Scenario, start while busy: start pulses during LATCH → run unaffected, pc not reset.
